// File: rtl/arbitro_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: fixed priority to port A).
package arbitro_pkg;

    localparam int ADDR_W_PADRAO = 7;
    localparam int DATA_W_PADRAO = 32;

    localparam bit PORTA_A = 1'b0;
    localparam bit PORTA_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } estado_t;

endpackage

// File: rtl/arbitro_memoria_dados_seletor.sv
// Winner selection between ports A and B; the tie policy lives here so the FSM stays policy-agnostic.
// ARB_ROUND_ROBIN_EN: ties go to the port not served last; otherwise port A always wins ties.
module seletor_prioridade
    import arbitro_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ultimo,
    output logic       vencedor,
    output logic       valido
);

    always_comb begin
        valido   = |req;
        // with no request the winner is a don't-care; echoing the pointer keeps it observable
        vencedor = ultimo;
`ifdef ARB_ROUND_ROBIN_EN
        if (req[PORTA_A] && req[PORTA_B])
            vencedor = ~ultimo;
        else if (req[PORTA_A])
            vencedor = PORTA_A;
        else if (req[PORTA_B])
            vencedor = PORTA_B;
`else
        if (req[PORTA_A])
            vencedor = PORTA_A;
        else if (req[PORTA_B])
            vencedor = PORTA_B;
`endif
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter/sequencer for the single-port data memory: IDLE -> ACCESS -> DONE per access.
// Tie policy selected by ARB_ROUND_ROBIN_EN (see seletor_prioridade).
module arbitro_memoria_dados
    import arbitro_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter int DATA_W = DATA_W_PADRAO
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic              busy,
    output logic              mem_ler,
    output logic              mem_escrever,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_dado_escrever,
    input  logic [DATA_W-1:0] mem_dado_ler
);

    estado_t estado, proximo;
    logic    we_l;
    logic    dono;
    logic    ultimo;
    logic    vencedor;
    logic    valido;
    logic    concede;

    seletor_prioridade u_seletor (
        .req      ({b_req, a_req}),
        .ultimo   (ultimo),
        .vencedor (vencedor),
        .valido   (valido)
    );

    assign concede = (estado == IDLE) && valido;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= IDLE;
        else       estado <= proximo;
    end

    // requests are only looked at in IDLE, so DONE cannot re-serve a request still held high
    always_comb begin
        proximo = estado;
        case (estado)
            IDLE:    if (valido) proximo = ACCESS;
            ACCESS:  proximo = DONE;
            DONE:    proximo = IDLE;
            default: proximo = IDLE;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        ultimo <= PORTA_B;
        else if (concede) ultimo <= vencedor;
    end
`else
    assign ultimo = PORTA_B;
`endif

    // address/data registers double as the memory-facing outputs and hold between accesses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_l              <= 1'b0;
            dono              <= PORTA_A;
            mem_endereco      <= '0;
            mem_dado_escrever <= '0;
        end else if (concede) begin
            dono <= vencedor;
            if (vencedor == PORTA_B) begin
                we_l              <= b_we;
                mem_endereco      <= b_addr;
                mem_dado_escrever <= b_wdata;
            end else begin
                we_l              <= a_we;
                mem_endereco      <= a_addr;
                mem_dado_escrever <= a_wdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_ack <= (estado == ACCESS) && (dono == PORTA_A);
            b_ack <= (estado == ACCESS) && (dono == PORTA_B);
            if ((estado == ACCESS) && !we_l) begin
                if (dono == PORTA_B) b_rdata <= mem_dado_ler;
                else                 a_rdata <= mem_dado_ler;
            end
        end
    end

    assign busy         = (estado != IDLE);
    assign mem_ler      = (estado == ACCESS) && !we_l;
    assign mem_escrever = (estado == ACCESS) && we_l;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Scoreboard bench for arbitro_memoria_dados: drivers push expected rdata per port, a monitor pops on ack.
module tb_arbitro_memoria_dados;
    import arbitro_pkg::*;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          busy, mem_ler, mem_escrever;
    logic [AW-1:0] mem_endereco;
    logic [DW-1:0] mem_dado_escrever, mem_dado_ler;

    always #5 clock = ~clock;

    arbitro_memoria_dados #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .mem_ler(mem_ler), .mem_escrever(mem_escrever), .mem_endereco(mem_endereco),
        .mem_dado_escrever(mem_dado_escrever), .mem_dado_ler(mem_dado_ler)
    );

    // the physical memory the arbiter drives; garbage on the read port when mem_ler is low
    logic [DW-1:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        forever begin
            @(posedge clock);
            if (mem_escrever) mem[mem_endereco] = mem_dado_escrever;
        end
    end
    always_comb mem_dado_ler = mem_ler ? mem[mem_endereco] : 32'hBAD0_BAD0;

    // reference model: memory contents and last read value per port, in program order
    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] ult_leitura [2];
    logic [DW-1:0] esp_a[$], esp_b[$];
    int            ack_port[$], ack_cyc[$];
    int            checks = 0, errors = 0, ciclo = 0, n_wr = 0, n_rd = 0;
    logic [AW-1:0] ult_wr_addr = '0;

    task automatic verifica(input string nome, input logic [127:0] obtido, input logic [127:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, obtido, esperado, ciclo);
        end
    endtask

    initial forever begin
        @(posedge clock);
        ciclo++;
    end

    // monitor: pops expectations on every ack and records completion order
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (a_ack) begin
                ack_port.push_back(0);
                ack_cyc.push_back(ciclo);
                if (esp_a.size() == 0) verifica("a_ack_unexpected", 1, 0);
                else                   verifica("a_rdata", a_rdata, esp_a.pop_front());
            end
            if (b_ack) begin
                ack_port.push_back(1);
                ack_cyc.push_back(ciclo);
                if (esp_b.size() == 0) verifica("b_ack_unexpected", 1, 0);
                else                   verifica("b_rdata", b_rdata, esp_b.pop_front());
            end
            if (a_ack || b_ack) verifica("ack_exclusive", a_ack & b_ack, 0);
            if (mem_ler || mem_escrever) verifica("mem_ctrl_exclusive", mem_ler & mem_escrever, 0);
            if (mem_escrever) begin
                n_wr++;
                ult_wr_addr = mem_endereco;
            end
            if (mem_ler) n_rd++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic espera(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // issue one access (caller is at #1 after a posedge); segura keeps req high through the ack cycle
    task automatic transacao(input bit p, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                             input bit segura, output int lat);
        int            t0;
        bit            ok;
        logic [DW-1:0] esp;
        if (we) begin
            ref_mem[ad] = wd;
            esp = ult_leitura[p];
        end else begin
            esp = ref_mem[ad];
            ult_leitura[p] = esp;
        end
        if (p) esp_b.push_back(esp);
        else   esp_a.push_back(esp);
        t0 = ciclo;
        if (p) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
        else   begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (p ? b_ack : a_ack) begin
                ok = 1;
                break;
            end
        end
        lat = ciclo - t0;
        if (!ok) verifica(p ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        if (segura) espera(1);
        if (p) b_req = 0;
        else   a_req = 0;
    endtask

    task automatic pulsa_reset();
        reset = 1;
        a_req = 0;
        b_req = 0;
        ult_leitura[0] = '0;
        ult_leitura[1] = '0;
        espera(2);
        reset = 0;
        verifica("reset_outputs",
                 {a_ack, b_ack, busy, mem_ler, mem_escrever, mem_endereco, mem_dado_escrever, a_rdata, b_rdata}, '0);
    endtask

    int            lat, n0;
    logic [DW-1:0] v127, v0;

    initial begin
        reset = 1;
        {a_req, a_we, b_req, b_we} = '0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        ult_leitura[0] = '0;
        ult_leitura[1] = '0;
        espera(1);
        pulsa_reset();

        // A write then read of address 5
        n0 = n_wr;
        transacao(0, 1, 7'd5, 32'hDEADBEEF, 0, lat);
        verifica("wr_latency", lat, 2);
        espera(2);
        verifica("wr_count", n_wr - n0, 1);
        verifica("wr_addr", ult_wr_addr, 5);
        n0 = n_rd;
        transacao(0, 0, 7'd5, '0, 0, lat);
        verifica("rd_latency", lat, 2);
        espera(2);
        verifica("rd_count", n_rd - n0, 1);
        verifica("a_rdata_held", a_rdata, 32'hDEADBEEF);

        // req held through the ack cycle must not cause a second access
        n0 = n_wr;
        transacao(0, 1, 7'd20, $urandom, 1, lat);
        espera(4);
        verifica("hold_single_write", n_wr - n0, 1);
        verifica("hold_idle", busy, 0);

        // address boundaries
        v127 = $urandom;
        v0   = ~v127;
        transacao(0, 1, 7'd127, v127, 0, lat);
        transacao(0, 1, 7'd0, v0, 0, lat);
        transacao(0, 0, 7'd127, '0, 0, lat);
        transacao(0, 0, 7'd0, '0, 0, lat);
        espera(2);

        // simultaneous continuous requests from both ports
        pulsa_reset();
        ack_port.delete();
        ack_cyc.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) transacao(0, 0, 7'(10 + i), '0, 0, lat);
            end
            begin
                int lb;
                for (int i = 0; i < 4; i++) transacao(1, 0, 7'(70 + i), '0, 0, lb);
            end
        join
        espera(2);
        verifica("tie_count", ack_port.size(), 8);
        for (int i = 0; i < 8 && i < ack_port.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            verifica("tie_order", ack_port[i], i % 2);
`else
            verifica("tie_order", ack_port[i], (i < 4) ? 0 : 1);
`endif
            if (i > 0) verifica("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // randomized traffic, disjoint address halves per port
        fork
            begin
                int la;
                for (int i = 0; i < 150; i++) begin
                    transacao(0, 1'($urandom), 7'($urandom_range(0, 63)), $urandom, 0, la);
                    espera($urandom_range(0, 4));
                end
            end
            begin
                int lb;
                for (int i = 0; i < 150; i++) begin
                    transacao(1, 1'($urandom), 7'($urandom_range(64, 127)), $urandom, 0, lb);
                    espera($urandom_range(0, 3));
                end
            end
        join
        espera(4);
        verifica("queue_a_drained", esp_a.size(), 0);
        verifica("queue_b_drained", esp_b.size(), 0);

        // reset during a B write's ACCESS cycle
        b_req = 1; b_we = 1; b_addr = 7'd9; b_wdata = 32'h1234_5678;
        espera(1);
        verifica("b_access_active", {mem_escrever, mem_endereco}, {1'b1, 7'd9});
        reset = 1;
        b_req = 0;
        #1;
        verifica("reset_drops_write", {mem_escrever, busy}, 2'b00);
        ult_leitura[0] = '0;
        ult_leitura[1] = '0;
        espera(1);
        reset = 0;
        verifica("reset_mid_outputs",
                 {a_ack, b_ack, busy, mem_ler, mem_escrever, mem_endereco, mem_dado_escrever, a_rdata, b_rdata}, '0);
        espera(5);
        transacao(0, 0, 7'd5, '0, 0, lat);
        verifica("post_reset_latency", lat, 2);
        espera(4);
        verifica("final_queue_a", esp_a.size(), 0);
        verifica("final_queue_b", esp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

Two-port arbiter and access sequencer for the single-port 128×32 data memory. It shares the memory between the processor load/store path (port A) and the UART debug/loader bridge (port B). Each granted access is latched and presented to the memory for exactly one cycle, and the requester gets a one-cycle acknowledge with registered read data. The block sits between both masters and the data memory; neither master drives the memory directly.

## Interface
- ADDR_W, 7, word-address width (128 words)
- DATA_W, 32, data width
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- a_req  in  1  port A request; level, held until a_ack
- a_we  in  1  port A write (1) / read (0); stable while a_req
- a_addr  in  ADDR_W  port A word address; stable while a_req
- a_wdata  in  DATA_W  port A write data; stable while a_req
- a_ack  out  1  one-cycle completion pulse to port A
- a_rdata  out  DATA_W  registered read data; valid when a_ack is high, held until the next port A read completes
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B
- busy  out  1  high in ACCESS and DONE
- mem_ler  out  1  memory read enable
- mem_escrever  out  1  memory write enable
- mem_endereco  out  ADDR_W  memory address
- mem_dado_escrever  out  DATA_W  memory write data
- mem_dado_ler  in  DATA_W  memory read data (combinational); valid only while mem_ler is high

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner, latch its we/addr/wdata and owner ID, and go to ACCESS.
- ACCESS:
  - Drive memory from the latched fields.
  - Latched read: mem_ler=1, mem_escrever=0. Latched write: mem_escrever=1, mem_ler=0.
  - At the closing edge: a write commits; a read captures mem_dado_ler into the owner's rdata register; the owner's ack is set; go to DONE.
- DONE:
  - Owner's ack is high for this cycle only. Memory controls are 0.
  - Both requests are ignored this cycle, so a requester cannot be served twice for one request.
  - Next state is IDLE.
- Outside ACCESS: mem_ler=0, mem_escrever=0, and mem_endereco/mem_dado_escrever hold their last latched value.
- Selection when only one port requests: that port wins.
- Selection when both request in the same IDLE cycle: decided by the configured policy (see Configuration).
- The losing port's request stays pending and is re-evaluated at the next IDLE.
- Writes never update rdata.
- Reset values: all outputs 0, state IDLE, latched fields 0, rdata registers 0, round-robin pointer = "B served last" (so A wins the first tie).
- Reset asserted during ACCESS: mem_escrever drops immediately, no write is guaranteed to commit, no ack is issued, and the requester must re-request.
- A requester dropping req before its ack is a protocol violation; the latched access still completes and still acks.

## Timing
- Request sampled at edge N. ACCESS runs in cycle N+1. ack is high in cycle N+2, and rdata is valid in that same cycle.
- Latency is 2 cycles from the request-sampling edge to ack. Occupancy is 3 cycles per access.
- Maximum throughput is one access per 3 cycles, aggregate across both ports.
- With both ports continuously requesting in round-robin mode, grants alternate A, B, A, … and each port completes one access every 6 cycles.
- No combinational path from any request input to any memory or ack output; all outputs are registered or decoded from registered state.

## Configuration
- ARB_ROUND_ROBIN_EN defined: ties go to the port not served most recently. The pointer updates at every grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, port A always wins ties. The pointer logic is absent. Port B can starve under continuous A traffic; this is accepted behaviour.

## Structure
- Package arbitro_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - port ID constants PORTA_A=0, PORTA_B=1
  - default ADDR_W/DATA_W localparams
- Sub-module seletor_prioridade: inputs req pair and last-served pointer; outputs winner ID and valid. It contains the macro-controlled policy, so the top FSM is policy-agnostic.

## Test plan
- Reset, then A writes 0xDEADBEEF to address 5 -> mem_escrever=1 with address 5 in exactly one cycle; a_ack one cycle later; b_ack stays 0.
- A reads address 5 -> a_ack 2 cycles after the request edge with a_rdata=0xDEADBEEF; mem_ler=1 for exactly one cycle.
- A and B request in the same cycle, held continuously, round-robin build -> completions A, B, A, B at 3-cycle spacing; fixed build -> only A completes while A holds its request.
- Requester holds req through its ack cycle and drops it after -> exactly one access and one ack, no duplicate write.
- Address 127 write/read, then address 0 -> correct data at both boundaries, no aliasing.
- reset pulsed mid-ACCESS of a B write to address 9 -> no b_ack; outputs return to 0; a subsequent A read succeeds with normal latency.
